// File: rtl/top.sv
// Register and ALU stage of the basic 16-bit processor.
// Holds the instruction register IR, a 32 x 16-bit register file GPR and
// the product-high register SGPR. The instruction in IR executes on every
// rising clock edge and its result is written back on that same edge.
//
// Ports:
//   clk       system clock, rising edge active
//   rst       asynchronous active-high reset (clears IR, GPR, SGPR)
//   instr_in  instruction word loaded into IR when instr_we is high
//   instr_we  IR load strobe; the loaded word executes on the following edge
//   rd_sel    debug read select into GPR
//   rd_data   combinational GPR[rd_sel]
//   sgpr_out  current SGPR contents
module top (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_in,
   input  logic        instr_we,
   input  logic [4:0]  rd_sel,
   output logic [15:0] rd_data,
   output logic [15:0] sgpr_out
);

   localparam int unsigned DW   = 16;
   localparam int unsigned PW   = 2 * DW;
   localparam int unsigned IW   = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;

   localparam logic [AW-1:0] OP_MOVSGPR = 5'd0;
   localparam logic [AW-1:0] OP_MOV     = 5'd1;
   localparam logic [AW-1:0] OP_ADD     = 5'd2;
   localparam logic [AW-1:0] OP_SUB     = 5'd3;
   localparam logic [AW-1:0] OP_MUL     = 5'd4;
   localparam logic [AW-1:0] OP_OR      = 5'd5;
   localparam logic [AW-1:0] OP_AND     = 5'd6;
   localparam logic [AW-1:0] OP_XOR     = 5'd7;
   localparam logic [AW-1:0] OP_XNOR    = 5'd8;
   localparam logic [AW-1:0] OP_NAND    = 5'd9;
   localparam logic [AW-1:0] OP_NOR     = 5'd10;
   localparam logic [AW-1:0] OP_NOT     = 5'd11;

   logic [IW-1:0] IR;
   logic [DW-1:0] GPR [NREG];
   logic [DW-1:0] SGPR;

   // Instruction field decode; isrc overlaps rsrc2
   logic [AW-1:0] oper_type;
   logic [AW-1:0] rdst;
   logic [AW-1:0] rsrc1;
   logic          imm_mode;
   logic [AW-1:0] rsrc2;
   logic [DW-1:0] isrc;

   assign oper_type = IR[31:27];
   assign rdst      = IR[26:22];
   assign rsrc1     = IR[21:17];
   assign imm_mode  = IR[16];
   assign rsrc2     = IR[15:11];
   assign isrc      = IR[15:0];

   // Operand selection
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [PW-1:0] prod;

   assign op_a = GPR[rsrc1];
   assign op_b = imm_mode ? isrc : GPR[rsrc2];
   assign prod = PW'(op_a) * PW'(op_b);

   // ALU result and write enables
   logic [DW-1:0] result;
   logic          gpr_we;
   logic          sgpr_we;

   always_comb begin
      result  = '0;
      gpr_we  = 1'b0;
      sgpr_we = 1'b0;
      case (oper_type)
         OP_MOVSGPR: begin result = SGPR;                               gpr_we = 1'b1; end
         OP_MOV:     begin result = imm_mode ? isrc : op_a;             gpr_we = 1'b1; end
         OP_ADD:     begin result = op_a + op_b;                        gpr_we = 1'b1; end
         OP_SUB:     begin result = op_a - op_b;                        gpr_we = 1'b1; end
         OP_MUL:     begin result = prod[DW-1:0]; gpr_we = 1'b1; sgpr_we = 1'b1; end
         OP_OR:      begin result = op_a | op_b;                        gpr_we = 1'b1; end
         OP_AND:     begin result = op_a & op_b;                        gpr_we = 1'b1; end
         OP_XOR:     begin result = op_a ^ op_b;                        gpr_we = 1'b1; end
         OP_XNOR:    begin result = ~(op_a ^ op_b);                     gpr_we = 1'b1; end
         OP_NAND:    begin result = ~(op_a & op_b);                     gpr_we = 1'b1; end
         OP_NOR:     begin result = ~(op_a | op_b);                     gpr_we = 1'b1; end
         OP_NOT:     begin result = imm_mode ? ~isrc : ~op_a;           gpr_we = 1'b1; end
         default:    begin result = '0;                                 gpr_we = 1'b0; end
      endcase
   end

   // Execute current IR and optionally load the next instruction on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         IR   <= '0;
         SGPR <= '0;
         for (int i = 0; i < NREG; i++) begin
            GPR[i] <= '0;
         end
      end else begin
         if (gpr_we) begin
            GPR[rdst] <= result;
         end
         if (sgpr_we) begin
            SGPR <= prod[PW-1:DW];
         end
         if (instr_we) begin
            IR <= instr_in;
         end
      end
   end

   assign rd_data  = GPR[rd_sel];
   assign sgpr_out = SGPR;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed ISA cases plus randomized instruction
// streams checked every cycle against an instruction-level model.
module tb_top;

   logic        clk;
   logic        rst;
   logic [31:0] instr_in;
   logic        instr_we;
   logic [4:0]  rd_sel;
   logic [15:0] rd_data;
   logic [15:0] sgpr_out;

   int checks   = 0;
   int failures = 0;

   top dut (
      .clk      (clk),
      .rst      (rst),
      .instr_in (instr_in),
      .instr_we (instr_we),
      .rd_sel   (rd_sel),
      .rd_data  (rd_data),
      .sgpr_out (sgpr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction-level model state
   logic [15:0] m_gpr [32];
   logic [15:0] m_sgpr;
   logic [31:0] m_ir;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // One architectural step: sources are read before the destination is written
   task automatic model_step();
      int unsigned op, rd, rs1, rs2, a, b, p;
      logic        imm;
      logic [15:0] isrc;
      op   = int'(m_ir[31:27]);
      rd   = int'(m_ir[26:22]);
      rs1  = int'(m_ir[21:17]);
      imm  = m_ir[16];
      rs2  = int'(m_ir[15:11]);
      isrc = m_ir[15:0];
      a    = int'(m_gpr[rs1]);
      b    = imm ? int'(isrc) : int'(m_gpr[rs2]);
      p    = a * b;
      case (op)
         0:  m_gpr[rd] = m_sgpr;
         1:  m_gpr[rd] = imm ? isrc : 16'(a);
         2:  m_gpr[rd] = 16'((a + b) % 65536);
         3:  m_gpr[rd] = 16'((a + 65536 - b) % 65536);
         4:  begin m_gpr[rd] = 16'(p % 65536); m_sgpr = 16'(p / 65536); end
         5:  m_gpr[rd] = 16'(a | b);
         6:  m_gpr[rd] = 16'(a & b);
         7:  m_gpr[rd] = 16'(a ^ b);
         8:  m_gpr[rd] = 16'(65535 - (a ^ b));
         9:  m_gpr[rd] = 16'(65535 - (a & b));
         10: m_gpr[rd] = 16'(65535 - (a | b));
         11: m_gpr[rd] = imm ? 16'(65535 - int'(isrc)) : 16'(65535 - a);
         default: ;
      endcase
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_gpr[i] = '0;
         m_sgpr = '0;
         m_ir   = '0;
      end else begin
         model_step();
         if (instr_we) m_ir = instr_in;
      end
   end

   // Per-cycle comparison of all architectural state
   always @(posedge clk) begin
      #1;
      check("rd_data", 32'(rd_data), 32'(m_gpr[rd_sel]));
      check("sgpr_out", 32'(sgpr_out), 32'(m_sgpr));
      check("ir", dut.IR, m_ir);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("gpr%0d", i), 32'(dut.GPR[i]), 32'(m_gpr[i]));
      end
   end

   function automatic logic [31:0] ri(input int op, input int rd, input int rs1, input logic [15:0] imm16);
      return {5'(op), 5'(rd), 5'(rs1), 1'b1, imm16};
   endfunction

   function automatic logic [31:0] rr(input int op, input int rd, input int rs1, input int rs2);
      return {5'(op), 5'(rd), 5'(rs1), 1'b0, 5'(rs2), 11'd0};
   endfunction

   task automatic issue(input logic [31:0] w);
      @(negedge clk);
      instr_in = w;
      instr_we = 1'b1;
      @(posedge clk);
   endtask

   task automatic flush();
      @(negedge clk);
      instr_we = 1'b0;
      @(posedge clk);
      #2;
   endtask

   task automatic run(input logic [31:0] w);
      issue(w);
      flush();
   endtask

   // Literal expectation pinned on both DUT and model
   task automatic chk_lit(input string name, input int idx, input logic [15:0] exp);
      check({name, "_dut"}, 32'(dut.GPR[idx]), 32'(exp));
      check({name, "_model"}, 32'(m_gpr[idx]), 32'(exp));
   endtask

   task automatic chk_sgpr(input string name, input logic [15:0] exp);
      check({name, "_dut"}, 32'(sgpr_out), 32'(exp));
      check({name, "_model"}, 32'(m_sgpr), 32'(exp));
   endtask

   initial begin
      rst      = 1'b1;
      instr_in = '0;
      instr_we = 1'b0;
      rd_sel   = '0;
      #2;
      check("reset_rd_data", 32'(rd_data), 32'h0);
      check("reset_sgpr", 32'(sgpr_out), 32'h0);
      check("reset_ir", dut.IR, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Preload every register with 2
      for (int r = 0; r < 32; r++) issue(ri(1, r, 0, 16'd2));
      flush();
      chk_lit("preload0", 0, 16'd2);
      chk_lit("preload31", 31, 16'd2);

      run(ri(2, 0, 2, 16'd4));          chk_lit("addi", 0, 16'd6);
      run(rr(2, 0, 4, 5));              chk_lit("add_reg", 0, 16'd4);
      run(ri(1, 4, 0, 16'd55));         chk_lit("movi", 4, 16'd55);
      run(rr(1, 4, 7, 0));              chk_lit("mov_reg", 4, 16'd2);
      run(rr(4, 4, 2, 3));              chk_lit("mul_small", 4, 16'd4);
      chk_sgpr("mul_small_hi", 16'h0000);
      run(ri(1, 10, 0, 16'h1234));
      run(ri(1, 11, 0, 16'h0100));
      run(rr(4, 12, 10, 11));           chk_lit("mul_big", 12, 16'h3400);
      chk_sgpr("mul_big_hi", 16'h0012);
      run(rr(0, 9, 0, 0));              chk_lit("movsgpr", 9, 16'h0012);

      run(rr(6, 13, 2, 3));             chk_lit("and_reg", 13, 16'd2);
      run(ri(6, 13, 2, 16'd10));        chk_lit("and_imm", 13, 16'd2);
      run(rr(5, 13, 2, 3));             chk_lit("or_reg", 13, 16'd2);
      run(ri(5, 13, 2, 16'd10));        chk_lit("or_imm", 13, 16'd10);
      run(rr(7, 13, 2, 3));             chk_lit("xor_reg", 13, 16'd0);
      run(ri(7, 13, 2, 16'd10));        chk_lit("xor_imm", 13, 16'd8);
      run(rr(8, 13, 2, 3));             chk_lit("xnor_reg", 13, 16'hFFFF);
      run(ri(8, 13, 2, 16'd10));        chk_lit("xnor_imm", 13, 16'hFFF7);
      run(rr(9, 13, 2, 3));             chk_lit("nand_reg", 13, 16'hFFFD);
      run(ri(9, 13, 2, 16'd10));        chk_lit("nand_imm", 13, 16'hFFFD);
      run(ri(1, 4, 0, 16'hFFFD));
      run(rr(10, 13, 4, 16));           chk_lit("nor_reg", 13, 16'h0000);
      run(ri(10, 13, 2, 16'd10));       chk_lit("nor_imm", 13, 16'hFFF5);
      run(rr(11, 13, 2, 0));            chk_lit("not_reg", 13, 16'hFFFD);
      run(ri(11, 13, 0, 16'd10));       chk_lit("not_imm", 13, 16'hFFF5);

      run(ri(1, 20, 0, 16'd0));
      run(ri(1, 21, 0, 16'd1));
      run(rr(3, 22, 20, 21));           chk_lit("sub_wrap", 22, 16'hFFFF);

      run(rr(20, 22, 20, 21));
      repeat (3) @(posedge clk);
      #2;
      chk_lit("nop_rdst", 22, 16'hFFFF);
      chk_lit("nop_other", 12, 16'h3400);
      chk_sgpr("nop_sgpr", 16'h0012);

      // Asynchronous reset mid-cycle
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) check($sformatf("async_rst_gpr%0d", i), 32'(dut.GPR[i]), 32'h0);
      check("async_rst_sgpr", 32'(sgpr_out), 32'h0);
      check("async_rst_ir", dut.IR, 32'h0);
      check("async_rst_rd_data", 32'(rd_data), 32'h0);
      @(negedge clk);
      rst      = 1'b0;
      instr_in = ri(1, 3, 0, 16'h00AB);
      instr_we = 1'b1;
      @(posedge clk);
      #2;
      chk_lit("latency_edge1", 3, 16'h0000);
      flush();
      chk_lit("latency_edge2", 3, 16'h00AB);

      // Randomized instruction stream with occasional async reset pulses
      repeat (3000) begin
         @(negedge clk);
         begin
            logic [4:0]  op, rd, rs1, rs2;
            logic [15:0] lo;
            logic        imm;
            op  = ($urandom % 8 == 0) ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11));
            rd  = 5'($urandom_range(0, 7));
            rs1 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs2 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            imm = 1'($urandom);
            lo  = 16'($urandom);
            instr_in = imm ? {op, rd, rs1, 1'b1, lo} : {op, rd, rs1, 1'b0, rs2, lo[10:0]};
            instr_we = ($urandom % 3 == 0);
            rd_sel   = 5'($urandom);
         end
         if ($urandom % 250 == 0) begin
            #1 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end
      @(negedge clk);
      instr_we = 1'b0;
      repeat (2) @(posedge clk);
      #3;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/top.md
Name: top

Overview:
- Single-cycle 16-bit arithmetic/logic execution core. This is the register and ALU stage of the basic processor.
- Contains a 32-bit instruction register IR, a 32-entry x 16-bit register file GPR[0..31], and a 16-bit special register SGPR for the upper half of a product.
- Executes the instruction held in IR on every clock edge and writes the result back to GPR/SGPR.
- Internal arrays are named exactly IR, GPR, SGPR so benches can access them hierarchically.

Parameters:
- none (widths fixed: data 16, IR 32, 32 registers)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- instr_in  input  32  instruction word to load into IR
- instr_we  input  1  load strobe for IR
- rd_sel  input  5  debug read select
- rd_data  output  16  combinational GPR[rd_sel]
- sgpr_out  output  16  current SGPR value

Behaviour:
- IR fields:
  - oper_type IR[31:27]
  - rdst IR[26:22]
  - rsrc1 IR[21:17]
  - imm_mode IR[16]
  - rsrc2 IR[15:11]
  - isrc IR[15:0], a 16-bit immediate that overlaps rsrc2.
- Reset (async, rst=1): IR, all GPR and SGPR are cleared to 0. rd_data therefore reads 0 and sgpr_out reads 0. Reset overrides any operation in progress.
- Each rising clk with rst=0:
  - Execute the current IR.
  - If instr_we=1, IR <= instr_in in the same edge. That instruction executes at the next edge; load-to-result latency is 2 edges.
  - A value placed in IR directly executes at the next edge.
- Operand B is isrc when imm_mode=1, otherwise GPR[rsrc2]. Operand A = GPR[rsrc1].
- Opcodes (all results are 16-bit and wrap; carry is discarded):
  - 0 MOVSGPR: GPR[rdst]=SGPR; imm_mode ignored.
  - 1 MOV: GPR[rdst] = imm ? isrc : GPR[rsrc1].
  - 2 ADD: A+B.
  - 3 SUB: A-B (two's complement wrap).
  - 4 MUL: full 32-bit product A*B (unsigned). GPR[rdst]=prod[15:0], SGPR=prod[31:16].
  - 5 OR: A|B.  6 AND: A&B.  7 XOR: A^B.  8 XNOR: ~(A^B).  9 NAND: ~(A&B).  10 NOR: ~(A|B).
  - 11 NOT: GPR[rdst] = imm ? ~isrc : ~GPR[rsrc1].
  - 12-31: no operation; no register changes.
- SGPR is written only by MUL.
- Execution repeats every cycle while IR is unchanged:
  - Results are stable when rdst is not a source.
  - Read-modify-write forms (rdst==rsrc1/rsrc2) update every cycle. This is intended.
- All sources are read before the write (the edge uses old values). rdst==rsrc is therefore legal.
- Register 0 is an ordinary writable register.
- rd_data/sgpr_out reflect register contents after the edge.

Test Plan:
Preload all GPR=2 via hierarchy; set IR fields directly and allow one clock edge per step.
- ADD: ADI rsrc1=2, isrc=4, rdst=0 -> GPR[0]=6. ADD reg rsrc1=4, rsrc2=5, rdst=0 -> GPR[0]=4.
- MOV: MOVI rdst=4, isrc=55 -> GPR[4]=55. MOV reg rdst=4, rsrc1=7 -> GPR[4]=2.
- MUL: 2*2, rdst=4 -> GPR[4]=4, SGPR=0. MUL with GPR values 0x1234 and 0x0100 -> low=0x3400, SGPR=0x0012. Then MOVSGPR rdst=9 -> GPR[9]=0x0012.
- AND/OR/XOR, operands 2 and 2 or 2 and imm 10:
  - AND reg -> 2; AND imm -> 2.
  - OR reg -> 2; OR imm -> 10.
  - XOR reg -> 0; XOR imm -> 8.
- XNOR/NAND/NOR/NOT:
  - XNOR reg -> 0xFFFF; XNOR imm -> 0xFFF7.
  - NAND reg/imm -> 0xFFFD.
  - NOR reg with GPR[4]=0xFFFD, GPR[16]=2 -> 0x0000; NOR imm(2,10) -> 0xFFF5.
  - NOT reg of 2 -> 0xFFFD; NOT imm 10 -> 0xFFF5.
- Reset and boundaries:
  - Assert rst mid-run -> all GPR, SGPR, IR read 0 immediately without waiting for clk.
  - After release, instr_in with instr_we -> result visible after the second edge.
  - SUB 0-1 -> 0xFFFF.
  - Opcode 20 -> no register changes.
